muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. Sits directly downstream of the decode stage and consumes its two register read operands and the R-format function field. It executes MULT, MULTU, DIV, DIVU (33 cycles each) and MTHI/MTLO (1 cycle), and exposes HI/LO for MFHI/MFLO. Busy is used by control to freeze PC and register writeback while an operation is in flight.

---
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Mul/div: accept -> 32 iterations -> sign fix/write; MTHI/MTLO write on accept.
module muldiv_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [5:0]  Func,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic [1:0]  state;
    logic [4:0]  counter;
    logic [63:0] acc;
    logic [31:0] b_mag;
    logic [31:0] a_raw;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;

    // Decode of the request presented this cycle.
    logic        is_muldiv_req;
    logic        is_div_req;
    logic        is_signed_req;
    logic [31:0] a_abs;
    logic [31:0] b_abs;

    always_comb begin
        is_muldiv_req = (Func == F_MULT) || (Func == F_MULTU) ||
                        (Func == F_DIV)  || (Func == F_DIVU);
        is_div_req    = (Func == F_DIV) || (Func == F_DIVU);
        is_signed_req = (Func == F_MULT) || (Func == F_DIV);
        a_abs         = (is_signed_req && A[31]) ? (32'd0 - A) : A;
        b_abs         = (is_signed_req && B[31]) ? (32'd0 - B) : B;
    end

    // One iteration of each algorithm; acc holds {high/rem, low/quo}.
    logic [32:0] mul_sum;
    logic [63:0] acc_mul;
    logic [64:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] acc_div;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, b_mag};
        acc_mul   = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
        div_shift = {acc, 1'b0};
        div_trial = div_shift[64:32] - {1'b0, b_mag};
        acc_div   = div_trial[32] ? div_shift[63:0]
                                  : {div_trial[31:0], div_shift[31:1], 1'b1};
    end

    // Sign correction applied in the write-back state.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        prod_fix = neg_res ? (64'd0 - acc) : acc;
        quo_fix  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            counter  <= 5'd0;
            acc      <= 64'd0;
            b_mag    <= 32'd0;
            a_raw    <= 32'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            Done     <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (Func == F_MTHI) begin
                            HI <= A;
                        end else if (Func == F_MTLO) begin
                            LO <= A;
                        end else if (is_muldiv_req) begin
                            is_div   <= is_div_req;
                            neg_res  <= is_signed_req && (A[31] ^ B[31]);
                            neg_rem  <= is_signed_req && A[31];
                            div_zero <= is_div_req && (B == 32'd0);
                            a_raw    <= A;
                            b_mag    <= b_abs;
                            acc      <= is_div_req ? {32'd0, a_abs} : {32'd0, a_abs};
                            counter  <= 5'd31;
                            state    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc <= is_div ? acc_div : acc_mul;
                    if (counter == 5'd0) begin
                        state <= S_FIX;
                    end else begin
                        counter <= counter - 5'd1;
                    end
                end
                S_FIX: begin
                    if (!is_div) begin
                        HI <= prod_fix[63:32];
                        LO <= prod_fix[31:0];
                    end else if (div_zero) begin
                        // Divide by zero is defined rather than trapped.
                        HI <= a_raw;
                        LO <= 32'hFFFF_FFFF;
                    end else begin
                        HI <= rem_fix;
                        LO <= quo_fix;
                    end
                    Done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Start = 1'b0;
    logic [5:0]  Func = 6'h0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_unit dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Func(Func), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on sign/zero-extended operands.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (f)
            F_MTHI: m_hi = a;
            F_MTLO: m_lo = a;
            F_MULT: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            F_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            F_DIV, F_DIVU: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else if (f == F_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic bit is_muldiv(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    // disturb: 0 = none, 1 = hold Start with a MULT during Busy, 2 = hold MTLO during Busy
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int disturb);
        logic [31:0] old_lo;
        int n;
        old_lo = m_lo;
        model(f, a, b);
        @(negedge CLK);
        Start = 1'b1; Func = f; A = a; B = b;
        @(posedge CLK); #1;
        if (!is_muldiv(f)) begin
            Start = 1'b0;
            check({tag, "_busy"}, {63'd0, Busy}, 64'd0);
            check({tag, "_hilo"}, {HI, LO}, {m_hi, m_lo});
            return;
        end
        check({tag, "_busy_on"}, {63'd0, Busy}, 64'd1);
        if (disturb == 0) begin
            Start = 1'b0;
        end else begin
            Func = (disturb == 1) ? F_MULT : F_MTLO;
            A = $urandom; B = $urandom;
        end
        n = 0;
        while (Busy && n < 60) begin
            @(posedge CLK); #1;
            n++;
            if (n == 10 && disturb == 2) check({tag, "_lo_hold"}, {32'd0, LO}, {32'd0, old_lo});
            if (n == 20) Start = 1'b0;
            if (Busy && Done) check({tag, "_done_early"}, {63'd0, Done}, 64'd0);
        end
        check({tag, "_busy_len"}, 64'(n), 64'd33);
        check({tag, "_done"}, {63'd0, Done}, 64'd1);
        check({tag, "_hilo"}, {HI, LO}, {m_hi, m_lo});
        @(posedge CLK); #1;
        check({tag, "_done_off"}, {62'd0, Done, Busy}, 64'd0);
    endtask

    initial begin
        logic [5:0]  funcs [6];
        logic [31:0] specials [5];
        logic [31:0] ra, rb;
        logic [5:0]  rf;
        bit          saw_done;

        funcs = '{F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
        specials = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF};

        RST = 1'b1;
        #12;
        check("rst_state", {30'd0, Busy, Done, HI, LO}, 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd5, 0);
        check("mult_neg_const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        check("multu_max_const", {HI, LO}, {32'hFFFF_FFFE, 32'h0000_0001});
        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg_const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("divu", F_DIVU, 32'd7, 32'd2, 0);
        check("divu_const", {HI, LO}, {32'd1, 32'd3});
        run_op("divu_zero", F_DIVU, 32'd7, 32'd0, 0);
        check("divu_zero_const", {HI, LO}, {32'd7, 32'hFFFF_FFFF});
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_const", {HI, LO}, {32'd0, 32'h8000_0000});
        run_op("mthi", F_MTHI, 32'h1234_5678, 32'd0, 0);
        check("mthi_const", {32'd0, HI}, {32'd0, 32'h1234_5678});
        run_op("div_mtlo", F_DIV, 32'd100, 32'hFFFF_FFFD, 2);
        run_op("bad_func", 6'h20, 32'hDEAD_BEEF, 32'd3, 0);

        // Reset in the middle of a divide.
        @(negedge CLK);
        Start = 1'b1; Func = F_DIV; A = 32'd1000; B = 32'd7;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (9) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("rst_mid", {30'd0, Busy, Done, HI, LO}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge CLK);
        RST = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (Done || Busy) saw_done = 1'b1;
        end
        check("rst_no_done", {63'd0, saw_done}, 64'd0);
        run_op("mult_6x7", F_MULT, 32'd6, 32'd7, 0);
        check("mult_6x7_const", {HI, LO}, {32'd0, 32'd42});

        for (int i = 0; i < 40; i++) begin
            rf = funcs[$urandom_range(5, 0)];
            ra = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(4, 0)] : $urandom;
            rb = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(4, 0)] : $urandom;
            if ($urandom_range(2, 0) == 0) rb = rb >> $urandom_range(31, 1);
            run_op("rand", rf, ra, rb, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
